// File: rtl/stac_master_if.sv
`default_nettype none
// ============================================================================
// Module      : stac_master_if
// Description : Command/response and serial pin bundle of the STAC host master.
// Revision    : 1.0 - initial release
// ============================================================================
interface stac_master_if #(
    parameter int MAXLEN = 33,
    parameter int LW     = 6
);
    logic              start;
    logic [1:0]        op;
    logic [LW-1:0]     len;
    logic [MAXLEN-1:0] din;
    logic              busy;
    logic              done;
    logic              err;
    logic [MAXLEN-1:0] dout;
    logic              TMS;
    logic              WSI;
    logic              WSO;

    modport master (
        input  start, op, len, din, WSO,
        output busy, done, err, dout, TMS, WSI
    );

    modport slave (
        output start, op, len, din, WSO,
        input  busy, done, err, dout, TMS, WSI
    );
endinterface
`default_nettype wire

// File: rtl/stac_master.sv
`default_nettype none
// ============================================================================
// Module      : stac_master
// Description : Generates TMS/WSI symbol streams for IR/DR scans and TAP
//               resets on the STAC wrapper port and captures WSO.
// Revision    : 1.0 - initial release
// ============================================================================
module stac_master #(
    parameter int MAXLEN = 33,
    parameter int LW     = 6
) (
    input  logic          TCLK,
    input  logic          TRESET,
    stac_master_if.master bus
);

    localparam logic [3:0] c_RST_SEQ = 4'd0;
    localparam logic [3:0] c_IDLE    = 4'd1;
    localparam logic [3:0] c_SEL_DR  = 4'd2;
    localparam logic [3:0] c_SEL_IR  = 4'd3;
    localparam logic [3:0] c_CAPTURE = 4'd4;
    localparam logic [3:0] c_SHIFT   = 4'd5;
    localparam logic [3:0] c_EXIT1   = 4'd6;
    localparam logic [3:0] c_UPDATE  = 4'd7;
    localparam logic [3:0] c_RETURN  = 4'd8;

    localparam logic [1:0]    c_OP_DR    = 2'b00;
    localparam logic [1:0]    c_OP_IR    = 2'b01;
    localparam logic [1:0]    c_OP_RST   = 2'b10;
    localparam logic [LW-1:0] c_ONE      = LW'(1);
    localparam logic [LW-1:0] c_RST_LAST = LW'(4);
    localparam logic [LW-1:0] c_MAXLEN   = LW'(MAXLEN);

    // r_state names the symbol currently on TMS/WSI, not the wrapper's TAP state
    logic [3:0]        r_state;
    logic [LW-1:0]     r_cnt;
    logic [1:0]        r_op;
    logic [LW-1:0]     r_len;
    logic [MAXLEN-1:0] r_din;
    logic [MAXLEN-1:0] r_shadow;
    logic [MAXLEN-1:0] r_dout;
    logic              r_auto;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_tms;
    logic              r_wsi;

    logic [3:0]        w_nxt_state;
    logic [LW-1:0]     w_nxt_cnt;
    logic              w_accept;
    logic              w_reject;
    logic              w_complete;
    logic              w_cmd_ok;
    logic              w_last_bit;
    logic              w_tms;
    logic              w_wsi;

    assign w_cmd_ok   = (bus.op == c_OP_RST) ||
                        (((bus.op == c_OP_DR) || (bus.op == c_OP_IR)) &&
                         (bus.len != '0) && (bus.len <= c_MAXLEN));
    assign w_last_bit = (r_cnt == (r_len - c_ONE));

    // State register; TMS/WSI are registered decodes of the upcoming state
    always_ff @(posedge TCLK) begin
        if (TRESET) begin
            r_state  <= c_RST_SEQ;
            r_cnt    <= '0;
            r_auto   <= 1'b1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_dout   <= '0;
            r_shadow <= '0;
            r_tms    <= 1'b1;
            r_wsi    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_busy  <= (w_nxt_state != c_IDLE);
            r_done  <= w_complete && !r_auto;
            r_err   <= w_reject;
            r_tms   <= w_tms;
            r_wsi   <= w_wsi;
            if (w_accept) begin
                r_auto   <= 1'b0;
                r_shadow <= '0;
            end
            if (r_state == c_SHIFT) begin
                r_shadow[r_cnt] <= bus.WSO;
            end
            if (w_complete && (r_state == c_UPDATE)) begin
                r_dout <= r_shadow;
            end
        end
    end

    always_ff @(posedge TCLK) begin
        if (w_accept) begin
            r_op  <= bus.op;
            r_len <= bus.len;
            r_din <= bus.din;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            c_RST_SEQ: begin
                if (r_cnt == c_RST_LAST) begin
                    w_nxt_state = c_RETURN;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + c_ONE;
                end
            end
            c_IDLE: begin
                if (bus.start) begin
                    if (w_cmd_ok) begin
                        w_accept    = 1'b1;
                        w_nxt_cnt   = '0;
                        w_nxt_state = (bus.op == c_OP_RST) ? c_RST_SEQ : c_SEL_DR;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            c_SEL_DR: begin
                w_nxt_cnt   = '0;
                w_nxt_state = (r_op == c_OP_IR) ? c_SEL_IR : c_CAPTURE;
            end
            c_SEL_IR: begin
                w_nxt_cnt   = '0;
                w_nxt_state = c_CAPTURE;
            end
            // Two TMS=0 symbols walk the wrapper through Capture into Shift
            c_CAPTURE: begin
                if (r_cnt == c_ONE) begin
                    w_nxt_state = c_SHIFT;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + c_ONE;
                end
            end
            c_SHIFT: begin
                if (w_last_bit) begin
                    w_nxt_state = c_EXIT1;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + c_ONE;
                end
            end
            c_EXIT1: w_nxt_state = c_UPDATE;
            c_UPDATE, c_RETURN: begin
                w_nxt_state = c_IDLE;
                w_complete  = 1'b1;
            end
            default: w_nxt_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_tms = 1'b0;
        w_wsi = 1'b0;
        case (w_nxt_state)
            c_RST_SEQ, c_SEL_DR, c_SEL_IR, c_EXIT1: w_tms = 1'b1;
            c_SHIFT: begin
                w_tms = (w_nxt_cnt == (r_len - c_ONE));
                w_wsi = r_din[w_nxt_cnt];
            end
            default: begin
                w_tms = 1'b0;
                w_wsi = 1'b0;
            end
        endcase
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.dout = r_dout;
    assign bus.TMS  = r_tms;
    assign bus.WSI  = r_wsi;

endmodule
`default_nettype wire

// File: doc/stac_master.md
# stac_master

Host-side controller that drives the serial test-access port of the STAC wrapper: it generates the TMS/WSI symbol stream for IR scans, DR scans and TAP resets, and samples WSO to return captured data. It sits between a parallel command source (test sequencer or bus bridge) and the wrapper's TMS/WSI/WSO pins. Both ends run on the same TCLK. The master launches symbols on one rising edge, and the wrapper samples them on the next rising edge.

## Interface
- MAXLEN, 33: maximum scan length in bits; must cover the widest IR or TDR.
- LW, 6: width of the length field; must satisfy 2^LW > MAXLEN.

- TCLK  in  1  test clock; all logic on the rising edge.
- TRESET  in  1  synchronous, active-high reset.
- start  in  1  command request; accepted only when busy=0.
- op  in  2  command: 00 DR scan, 01 IR scan, 10 TAP reset, 11 reserved.
- len  in  LW  scan length in bits for op 00/01.
- din  in  MAXLEN  shift-in data; bit 0 is shifted first.
- busy  out  1  high while a command or the post-reset sequence is in progress.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse when a command is rejected.
- dout  out  MAXLEN  data captured from WSO; bit 0 is captured first.
- TMS  out  1  TAP mode select to the wrapper; registered.
- WSI  out  1  serial data to the wrapper; registered.
- WSO  in  1  serial data from the wrapper.

## Operation
- States: RST_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RETURN.
- Idle symbol: TMS=0, WSI=0. This holds the wrapper in Run-Test/Idle.
- Command acceptance:
  - A command is accepted when start=1 and busy=0.
  - op, len and din are latched on the accepting edge. Later changes to them have no effect.
  - start while busy=1 is ignored: no err pulse, no queueing.
- Rejection:
  - Triggers: op=11, or op∈{00,01} with len=0 or len>MAXLEN.
  - Response: err pulses for 1 cycle, busy stays 0, dout is unchanged.
- DR scan symbol stream (TMS, one per cycle): 1, 0, 0, then len SHIFT symbols, then 1, 0.
  - SHIFT symbol i (i=0..len-1): WSI=din[i]; TMS=0, except TMS=1 on i=len-1.
  - Total: len+5 symbols.
- IR scan symbol stream: 1, 1, 0, 0, then len SHIFT symbols (same rule), then 1, 0.
  - Total: len+6 symbols.
- TAP reset: five TMS=1 symbols, then one TMS=0. Total: 6 symbols. WSI=0 throughout.
- WSO capture:
  - While SHIFT symbol i is presented, WSO is sampled on the edge that ends that cycle and stored into a shadow register bit i.
  - Shadow bits i ≥ len are forced to 0.
  - The shadow register is copied to dout when done asserts.
  - dout holds its value until the next successful scan completes. A TAP reset does not modify dout.
- Bit counter: LW-bit, counts SHIFT symbols 0..len-1. It never wraps, because len ≤ MAXLEN is enforced at acceptance.

## Timing
- TRESET=1 at an edge forces the following state, regardless of current state, including mid-scan:
  - TMS=1, WSI=0, done=0, err=0, dout=0, busy=1, state RST_SEQ.
- After TRESET deasserts, the master emits the 6-symbol TAP-reset stream, then enters IDLE.
  - busy falls with the first idle symbol.
  - No done pulse is produced for the automatic sequence.
- Accepting edge T:
  - busy=1 from T.
  - The first command symbol is presented on TMS/WSI in cycle T+1. This is the output registered at edge T.
- Symbol presentation: symbol k occupies cycle T+1+k. The wrapper samples it at the edge ending that cycle.
- Completion: for a command of S symbols, the final symbol occupies cycle T+S. At the edge ending it, all of the following happen together:
  - busy falls.
  - done=1 for exactly one cycle.
  - dout updates.
  - TMS/WSI return to the idle symbol.
- Back-to-back: start may be asserted in the done cycle. The next command's first symbol then follows with no gap.
- Rejection timing: err is high in the cycle after the rejecting edge. busy and TMS stay idle.

## Test plan
- Reset:
  - Stimulus: assert TRESET for 2 cycles, then release.
  - Required: TMS stream 1,1,1,1,1,0 with busy=1 for exactly 6 cycles after release; no done; dout=0.
- DR scan:
  - Stimulus: op=00, len=17, din=0x1ABCD, against a wrapper model whose 17-bit TDR captures 0x0002D.
  - Required: TMS stream 1,0,0, then sixteen 0s, then 1,1,0; WSI bits equal 0x1ABCD LSB-first; dout=0x0002D; done 22 cycles after acceptance.
- IR scan:
  - Stimulus: op=01, len=8, din=0x02.
  - Required: TMS stream 1,1,0,0, then seven 0s, then 1,1,0 (14 symbols); the model IR updates to 0x02 at the final edge; done pulses.
- Rejection:
  - Stimulus: len=0 with op=00, then op=11, then len=34.
  - Required: three single-cycle err pulses; busy never rises; TMS stays 0; dout unchanged.
- Overlapping start:
  - Stimulus: start a 33-bit DR scan, and pulse start again 5 cycles later.
  - Required: the second request is ignored; exactly one done, 38 cycles after the first acceptance.
- Reset mid-operation:
  - Stimulus: assert TRESET at SHIFT bit 10 of a 17-bit scan.
  - Required: next cycle TMS=1, dout=0, no done; the 6-symbol reset stream follows; a subsequent scan completes correctly.
